// File: rtl/bit_serializer_pkg.sv
// Shared defaults, minimum frame length and FSM state encoding for bit_serializer.
package bit_serializer_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int MOD_W_DEF  = 4;
  localparam int MIN_MOD    = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

endpackage

// File: rtl/bit_serializer.sv
// MSB-first parallel-to-serial converter with per-bit valid strobe.
// Optional trailing even-parity bit when BIT_SERIALIZER_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a request with N >= MIN_MOD
// SHIFT  | one data bit on the output per cycle; r_cnt = bits still to follow
// PARITY | even-parity bit on the output (parity build only)
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int MOD_W  = MOD_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);

  ser_state_t        r_state;
  logic [DATA_W-1:0] r_shift;
  logic [4:0]        r_cnt;
  logic              r_data;
  logic              r_val;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic              r_par;
`endif

  logic [4:0] w_n;
  logic       w_accept;

  // A zero count field selects the full word width.
  assign w_n      = (data_mod_i == '0) ? 5'(DATA_W) : 5'(data_mod_i);
  assign w_accept = data_val_i && (w_n >= 5'(MIN_MOD));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_data  <= 1'b0;
      r_val   <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_data <= 1'b0;
          r_val  <= 1'b0;
          if (w_accept) begin
            r_state <= SHIFT;
            r_data  <= data_i[DATA_W-1];
            r_val   <= 1'b1;
            r_shift <= {data_i[DATA_W-2:0], 1'b0};
            r_cnt   <= w_n - 5'd1;
`ifdef BIT_SERIALIZER_PARITY_EN
            r_par   <= data_i[DATA_W-1];
`endif
          end
        end
        SHIFT: begin
          if (r_cnt == 5'd0) begin
`ifdef BIT_SERIALIZER_PARITY_EN
            r_state <= PARITY;
            r_data  <= r_par;
            r_val   <= 1'b1;
`else
            r_state <= IDLE;
            r_data  <= 1'b0;
            r_val   <= 1'b0;
`endif
          end else begin
            r_data  <= r_shift[DATA_W-1];
            r_shift <= {r_shift[DATA_W-2:0], 1'b0};
            r_cnt   <= r_cnt - 5'd1;
`ifdef BIT_SERIALIZER_PARITY_EN
            r_par   <= r_par ^ r_shift[DATA_W-1];
`endif
          end
        end
        default: begin
          r_state <= IDLE;
          r_data  <= 1'b0;
          r_val   <= 1'b0;
        end
      endcase
    end
  end

  assign ser_data_o     = r_data;
  assign ser_data_val_o = r_val;
  assign busy_o         = r_val;

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Converts a parallel word of up to 16 bits into an MSB-first serial bit stream with a per-bit valid strobe. It sits directly upstream of the programmable 1-bit delay line `delay_15`: `ser_data_o` drives its `data_i`. The block accepts a word only when idle. While serializing, it reports `busy_o` so the producer can hold off.

## Interface
- `DATA_W`, default 16: parallel word width.
- `MOD_W`, default 4 (`$clog2(DATA_W)`): width of the bit-count field.
- `clk_i` input, 1 bit: single clock; all logic on its rising edge.
- `rst_i` input, 1 bit: reset, synchronous and active-high.
- `data_i` input, `DATA_W` bits: parallel word; bit `DATA_W-1` is sent first.
- `data_mod_i` input, `MOD_W` bits: number of bits to send; 0 means `DATA_W`.
- `data_val_i` input, 1 bit: request strobe; sampled only while `busy_o`=0.
- `ser_data_o` output, 1 bit: serial data bit.
- `ser_data_val_o` output, 1 bit: `ser_data_o` is valid this cycle.
- `busy_o` output, 1 bit: a frame is being sent; new requests are ignored.

## Operation
- FSM states are IDLE and SHIFT, plus PARITY when the parity feature is compiled in.
- IDLE → SHIFT: on an edge where `data_val_i`=1, `busy_o`=0 and the effective N ≥ 3.
  - Effective N is `data_mod_i`, or `DATA_W` when `data_mod_i`=0.
  - `data_i` and N are latched on that edge.
- N = 1 or 2: the request is dropped silently. The FSM stays in IDLE and no output toggles.
- SHIFT: each cycle presents one bit, MSB first: `data_i[DATA_W-1]`, then `data_i[DATA_W-2]`, and so on down to `data_i[DATA_W-N]`.
- A 5-bit counter tracks the bits sent. After the N-th bit the FSM goes to IDLE, or to PARITY if the feature is enabled.
- `busy_o` equals `ser_data_val_o` at all times.
- `ser_data_o` is forced to 0 whenever `ser_data_val_o`=0.
- `data_val_i` asserted while `busy_o`=1 is ignored. It is not queued.
- Changes to `data_i` and `data_mod_i` after acceptance have no effect on the frame in flight.

## Timing
- Reset value of every output is 0, and the FSM returns to IDLE.
- `rst_i` asserted mid-frame: the frame is aborted. All outputs read 0 in the cycle after the reset edge, and nothing resumes.
- Latency: request accepted on edge t. The first bit appears in the cycle following edge t, and `ser_data_val_o` stays high for exactly N consecutive cycles (N+1 with parity).
- Back-to-back frames: a request held during the last bit is ignored. `busy_o` falls the cycle after the last bit, and the next request can be accepted on that cycle's closing edge. The minimum gap is therefore one idle cycle between frames.
- `rst_i` and `data_val_i` on the same edge: reset wins and nothing is accepted.

## Configuration
- `BIT_SERIALIZER_PARITY_EN` defined:
  - After the N data bits, one extra cycle carries the even-parity bit, equal to the XOR of the N bits sent.
  - `ser_data_val_o` and `busy_o` stay high for N+1 cycles.
- Undefined: the PARITY state, the parity register and the extra cycle are absent; frames last exactly N cycles.

## Structure
- Package `bit_serializer_pkg` holds:
  - the `DATA_W` and `MOD_W` defaults;
  - the constant `MIN_MOD` = 3;
  - the FSM state enum `ser_state_t` (IDLE, SHIFT, PARITY).
- Single module, no sub-module. The shift register, counter and FSM are small and tightly coupled.
- `delay_15` is instantiated at the integration level, not inside this block.

## Test plan
- Full word: `data_i`=16'hA5F0, `data_mod_i`=0, one-cycle `data_val_i`.
  - Expect 16 valid cycles carrying 1010 0101 1111 0000, starting the cycle after acceptance.
  - `busy_o` high for exactly 16 cycles.
- Short word: `data_i`=16'hE000, `data_mod_i`=3.
  - Expect bits 1,1,1 over 3 valid cycles, then `busy_o`=0 and `ser_data_o`=0.
- Rejected counts: `data_mod_i`=1, then `data_mod_i`=2, each with `data_val_i`=1.
  - Expect `busy_o`, `ser_data_val_o` and `ser_data_o` to stay 0 for 20 cycles.
- Request during busy:
  - Start 16'hA5F0 with mod 0.
  - Pulse `data_val_i` with 16'hFFFF at bit 4 and again during the last bit.
  - Expect the stream unchanged, and the next frame accepted only once `busy_o`=0.
- Reset mid-frame: assert `rst_i` while bit 5 of 16'hA5F0 is on the output.
  - Expect all outputs 0 in the next cycle and no further valid bits.
- Parity build (`BIT_SERIALIZER_PARITY_EN`):
  - 16'hA5F0, mod 0: 17th valid bit = 0.
  - 16'hE000, mod 3: 4th valid bit = 1, `busy_o` high 4 cycles.
